uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the number of data bits per frame and the width of p_data.
REQ-002 Parameter PRESCALE_W, default 6, SHALL set the width of the prescale input.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 rx_in  input  1  SHALL be the asynchronous serial line: idle high, LSB first, start bit 0, stop bit 1.
REQ-006 prescale  input  PRESCALE_W  SHALL give clk cycles per bit; legal values are 8, 16 and 32.
REQ-007 par_en  input  1  SHALL mean a parity bit follows the data bits when high.
REQ-008 par_typ  input  1  SHALL select parity: 0 = even, 1 = odd.
REQ-009 p_data  output  DATA_WIDTH  SHALL carry the last good received word.
REQ-010 data_valid  output  1  SHALL pulse for one cycle when p_data updates.
REQ-011 par_err  output  1  SHALL pulse for one cycle on a parity mismatch.
REQ-012 stp_err  output  1  SHALL pulse for one cycle when the stop bit samples as 0.
REQ-013 busy  output  1  SHALL be high from start detection to frame completion.

Function
REQ-014 rx_in SHALL pass through a 2-flop synchronizer; the flops reset to 1; rx_s denotes the synchronized line.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-016 In IDLE, rx_s==0 SHALL define cycle T0: move to START; latch prescale (P), par_en and par_typ for the whole frame; set edge count 0.
REQ-017 A prescale value other than 8, 16 or 32 SHALL be latched as 8.
REQ-018 The edge counter SHALL run 0..P-1 per bit, wrap to 0, and advance the bit index on wrap; bit k, count c falls at cycle T0+k*P+c.
REQ-019 Each bit SHALL be sampled at counts P/2-1, P/2 and P/2+1; the majority of the three is the bit value, valid at count P/2+2.
REQ-020 START: a voted value of 1 SHALL be treated as a glitch: return to IDLE, drop busy, assert no outputs.
REQ-021 DATA: DATA_WIDTH voted bits SHALL be shifted in LSB first.
REQ-022 PARITY (only when par_en): expected bit = XOR of the data bits XOR par_typ; a voted-bit mismatch flags a parity error.
REQ-023 STOP: the frame SHALL be decided at count P/2+2 of the stop bit; the FSM then enters DONE for one cycle and returns to IDLE, so back-to-back frames are accepted.
REQ-024 DONE cycle = T0+(N-1)*P+P/2+3, where N = DATA_WIDTH+2 (+1 if par_en); in that cycle outputs SHALL be registered as follows.
REQ-025 No errors: p_data SHALL be loaded and data_valid pulsed.
REQ-026 Parity error or stop error: the matching err flag(s) SHALL pulse and p_data SHALL be held. Both errors in one frame pulse both flags.
REQ-027 busy SHALL fall in the cycle after DONE.
REQ-028 Changes to prescale, par_en or par_typ during a frame SHALL have no effect until the next T0.

Reset
REQ-029 Reset assertion SHALL immediately force: FSM to IDLE; counters and shift register to 0; p_data=0, data_valid=0, par_err=0, stp_err=0, busy=0; synchronizer flops to 1.
REQ-030 A reset mid-frame SHALL abandon the frame; after release, the next T0 needs rx_s==0 seen in IDLE.

Structure
REQ-031 The FSM state encoding and the legal prescale constants SHALL live in the shared UART package, alongside the TX definitions.
REQ-032 The 3-sample majority voter plus its sample-point logic SHALL be a sub-module named rx_data_sampler; the FSM, counters and deserializer stay in uart_rx.

Verification
REQ-033 P=8, par_en=1, par_typ=0, frame 0xA5 with parity bit 0 and stop 1 -> data_valid at T0+87, p_data=0xA5, no errors.
REQ-034 Same frame but parity bit 1 -> par_err pulse at T0+87, no data_valid, p_data unchanged.
REQ-035 P=16, par_en=0, frame 0x3C with stop bit 0 -> stp_err pulse at T0+155, no data_valid.
REQ-036 P=16, rx_in low for 3 cycles only -> busy high then low, no pulses, FSM back in IDLE.
REQ-037 P=32, par_en=0, frames 0x3C then 0xC3 back-to-back with one stop bit each -> two data_valid pulses, 320 cycles apart, p_data 0x3C then 0xC3.
REQ-038 rst low during DATA bit 4 -> all outputs 0 at once; after release, a clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX/TX FSM encodings and the legal prescale constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/rx_data_sampler.sv
// Mid-bit 3-sample majority voter; the vote is presented on the count after the last sample.
module rx_data_sampler #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rx_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             bit_o,
  output logic             vld_o
);

  logic [2:0] samp_q, samp_d;

  always_comb begin
    samp_d = samp_q;
    if (cnt_i == half_i - CNT_W'(1)) samp_d[0] = rx_i;
    if (cnt_i == half_i)             samp_d[1] = rx_i;
    if (cnt_i == half_i + CNT_W'(1)) samp_d[2] = rx_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) samp_q <= '0;
    else         samp_q <= samp_d;
  end

  assign bit_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign vld_o = (cnt_i == half_i + CNT_W'(2));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, per-bit edge counter and LSB-first deserializer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e               state_q, state_d;
  logic [1:0]              sync_q;
  logic                    rx_s;
  logic [PRESCALE_W-1:0]   cnt_q, cnt_d, p_q, p_d, half;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d, p_data_q, p_data_d;
  logic                    par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                    par_bad_q, par_bad_d;
  logic                    dv_q, dv_d, pe_q, pe_d, se_q, se_d, busy_q, busy_d;
  logic                    last, voted, vld;

  assign rx_s = sync_q[1];
  assign half = p_q >> 1;
  assign last = (cnt_q == p_q - PRESCALE_W'(1));

  rx_data_sampler #(.CNT_W(PRESCALE_W)) u_sampler (
    .clk_i  (clk),
    .rst_ni (rst),
    .rx_i   (rx_s),
    .cnt_i  (cnt_q),
    .half_i (half),
    .bit_o  (voted),
    .vld_o  (vld)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    busy_d    = busy_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;
    if (state_q != IDLE && state_q != DONE) cnt_d = last ? '0 : cnt_q + PRESCALE_W'(1);
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d   = START;
        cnt_d     = '0;
        idx_d     = '0;
        p_d       = prescale_legal(int'(prescale)) ? prescale : PRESCALE_W'(PRESCALE_8);
        par_en_d  = par_en;
        par_typ_d = par_typ;
        par_bad_d = 1'b0;
        busy_d    = 1'b1;
      end
      START: begin
        if (vld && voted) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (vld) shift_d = DATA_WIDTH'({voted, shift_q} >> 1);
        if (last) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (vld) par_bad_d = voted != (^shift_q ^ par_typ_q);
        if (last) state_d = STOP;
      end
      STOP: if (vld) begin
        // Outputs are registered on entry to DONE so they are visible during DONE.
        state_d = DONE;
        cnt_d   = '0;
        if (voted && !par_bad_q) begin
          p_data_d = shift_q;
          dv_d     = 1'b1;
        end else begin
          pe_d = par_bad_q;
          se_d = !voted;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      cnt_q     <= '0;
      p_q       <= PRESCALE_W'(PRESCALE_8);
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], rx_in};
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
      busy_q    <= busy_d;
    end
  end

  assign p_data     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; cycle indices count rising edges from the one after which rx_in first falls.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, par_typ;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err, busy;

  int checks = 0;
  int failures = 0;

  logic line_q[$];
  int   dv_n, pe_n, se_n, pe_at, se_at, busy_rise, busy_fall;
  int   dv_at [2];
  logic [7:0] dv_data [2];

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input int p, input bit par_on,
                           input bit par_bit, input bit stop_bit);
    repeat (p) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (p) line_q.push_back(d[i]);
    if (par_on) repeat (p) line_q.push_back(par_bit);
    repeat (p) line_q.push_back(stop_bit);
  endtask

  // Drives line_q one bit per cycle and logs output pulses by cycle index.
  task automatic run(input int ncyc, input int chg_at);
    logic busy_prev;
    dv_n = 0; pe_n = 0; se_n = 0; pe_at = -1; se_at = -1;
    busy_rise = -1; busy_fall = -1;
    dv_at[0] = -1; dv_at[1] = -1; dv_data[0] = '0; dv_data[1] = '0;
    busy_prev = busy;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk); #1;
      if (data_valid) begin
        if (dv_n < 2) begin dv_at[dv_n] = j; dv_data[dv_n] = p_data; end
        dv_n++;
      end
      if (par_err) begin pe_n++; pe_at = j; end
      if (stp_err) begin se_n++; se_at = j; end
      if (busy && !busy_prev && busy_rise < 0) busy_rise = j;
      if (!busy && busy_prev && busy_fall < 0) busy_fall = j;
      busy_prev = busy;
      if (j == chg_at) begin prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1; end
      rx_in = (j < line_q.size()) ? line_q[j] : 1'b1;
    end
    line_q.delete();
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    #2;
    chk("reset_p_data", 32'(p_data), 32'h0);
    chk("reset_flags", {28'h0, data_valid, par_err, stp_err, busy}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // P=8 even parity, good frame 0xA5
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    add_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    run(108, -1);
    chk("good_dv_count", 32'(dv_n), 32'd1);
    chk("good_dv_cycle", 32'(dv_at[0]), 32'd90);
    chk("good_dv_data", 32'(dv_data[0]), 32'hA5);
    chk("good_no_err", 32'(pe_n + se_n), 32'd0);
    chk("good_busy_rise", 32'(busy_rise), 32'd3);
    chk("good_busy_fall", 32'(busy_fall), 32'd91);

    // Same frame, wrong parity bit
    add_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    run(108, -1);
    chk("par_pe_count", 32'(pe_n), 32'd1);
    chk("par_pe_cycle", 32'(pe_at), 32'd90);
    chk("par_no_dv_se", 32'(dv_n + se_n), 32'd0);
    chk("par_p_data_held", 32'(p_data), 32'hA5);

    // Wrong parity and stop 0: both flags together
    add_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0);
    run(108, -1);
    chk("both_pe_cycle", 32'(pe_at), 32'd90);
    chk("both_se_cycle", 32'(se_at), 32'd90);
    chk("both_no_dv", 32'(dv_n), 32'd0);

    // P=16 no parity, stop 0; settings changed mid-frame must be ignored
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    add_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
    run(180, 20);
    chk("stp_se_count", 32'(se_n), 32'd1);
    chk("stp_se_cycle", 32'(se_at), 32'd158);
    chk("stp_no_dv_pe", 32'(dv_n + pe_n), 32'd0);
    chk("stp_p_data_held", 32'(p_data), 32'hA5);

    // P=16 start glitch of 3 cycles
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    repeat (3) line_q.push_back(1'b0);
    run(40, -1);
    chk("glitch_busy_rise", 32'(busy_rise), 32'd3);
    chk("glitch_busy_fall", 32'(busy_fall), 32'd14);
    chk("glitch_no_pulse", 32'(dv_n + pe_n + se_n), 32'd0);
    chk("glitch_busy_end", 32'(busy), 32'd0);

    // Illegal prescale 12 falls back to 8
    prescale = 6'd12; par_en = 1'b0;
    add_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
    run(100, -1);
    chk("illegal_dv_cycle", 32'(dv_at[0]), 32'd82);
    chk("illegal_dv_data", 32'(dv_data[0]), 32'h96);

    // P=32 back-to-back frames
    prescale = 6'd32; par_en = 1'b0;
    add_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1);
    add_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1);
    run(660, -1);
    chk("b2b_dv_count", 32'(dv_n), 32'd2);
    chk("b2b_dv0_cycle", 32'(dv_at[0]), 32'd310);
    chk("b2b_dv1_cycle", 32'(dv_at[1]), 32'd630);
    chk("b2b_dv0_data", 32'(dv_data[0]), 32'h3C);
    chk("b2b_dv1_data", 32'(dv_data[1]), 32'hC3);

    // Reset during data bit 4, then a clean frame
    prescale = 6'd16; par_en = 1'b0;
    add_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1);
    run(88, -1);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_p_data", 32'(p_data), 32'h0);
    chk("rst_flags", {28'h0, data_valid, par_err, stp_err, busy}, 32'h0);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    add_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1);
    run(180, -1);
    chk("post_rst_dv_count", 32'(dv_n), 32'd1);
    chk("post_rst_dv_cycle", 32'(dv_at[0]), 32'd158);
    chk("post_rst_dv_data", 32'(dv_data[0]), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
